jtag_mem_bridge: RTL
====================

Name: jtag_mem_bridge

Overview:
- CLK-domain command engine behind the virtual-JTAG scan chains. It replaces direct strobe decoding with a queued, parametrised bridge.
- Takes the held chain outputs plus the raw JTAG update pulse, synchronises the pulse and decodes a command.
- Runs single writes or auto-incrementing read bursts over a req/ack memory port.
- Buffers read data in a FIFO that JTAG drains one word per update.

Parameters:
AW, 8, address width; MEM_ADDR wraps modulo 2^AW
DW, 32, data width
LW, 4, burst-length field width; a burst is LEN+1 words
DEPTH, 8, read FIFO depth in words; power of two, at least 2
SYNC, 2, synchroniser stages for JT_UPDATE; at least 2

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset (0 = reset)
JT_UPDATE  in  1  raw update-DR level from TCK domain, asynchronous to CLK
JT_CMD  in  3  command code, stable while JT_UPDATE is high
JT_INC  in  1  auto-increment enable, latched by SETADDR
JT_ADDR  in  AW  address, latched by SETADDR
JT_LEN  in  LW  burst length minus one, latched by SETADDR
JT_WD  in  DW  write data
MEM_REQ  out  1  access request
MEM_WE  out  1  1 = write, 0 = read
MEM_ADDR  out  AW  access address
MEM_WD  out  DW  write data
MEM_ACK  in  1  one-cycle completion; read data valid in the same cycle
MEM_RD  in  DW  read data
RD_HEAD  out  DW  FIFO head word; 0 when empty
RD_COUNT  out  $clog2(DEPTH)+1  FIFO occupancy
BUSY  out  1  FSM not in IDLE
ERR  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, addr/len/inc registers 0, ERR 0.
- JT_UPDATE passes through a SYNC-stage flop chain and a rising-edge detector, giving a one-cycle strobe CMD_STB.
- On CMD_STB, JT_* inputs are sampled in the same cycle.
- Commands: 000 NOP; 001 SETADDR (addr<=JT_ADDR, len<=JT_LEN, inc<=JT_INC); 010 WRITE; 011 READ; 100 POP; 101 CLEAR; 11x NOP.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT.
- IDLE + WRITE: go to WR in the next cycle. MEM_REQ=1, MEM_WE=1, MEM_ADDR=addr, MEM_WD=JT_WD (WD captured at the strobe).
- WR: hold all outputs until MEM_ACK. On MEM_ACK, MEM_REQ drops in the next cycle, addr+=inc, go to IDLE.
- IDLE + READ: load the beat counter with len, go to RD_ISSUE.
- RD_ISSUE: assert MEM_REQ (MEM_WE=0) only when the FIFO is not full, counting any pop in the same cycle as freeing a slot. Otherwise stall in RD_ISSUE with MEM_REQ=0.
- Once MEM_REQ rises, hold it until MEM_ACK (RD_WAIT).
- On MEM_ACK: push MEM_RD, addr+=inc. If counter==0 go to IDLE; else decrement and return to RD_ISSUE. One idle cycle between beats is allowed.
- MEM_REQ, MEM_WE, MEM_ADDR and MEM_WD never change while MEM_REQ=1 and MEM_ACK=0.
- Latency: MEM_REQ is first high 2 CLK cycles after CMD_STB (strobe cycle, then state register).
- POP is accepted in any state. It removes the head the cycle after the strobe.
- A simultaneous push and pop keeps RD_COUNT unchanged.
- POP on an empty FIFO is ignored and sets ERR.
- CLEAR in IDLE empties the FIFO and clears ERR. CLEAR while BUSY is ignored and sets ERR.
- SETADDR, WRITE or READ while BUSY is dropped, sets ERR, and leaves state untouched.
- The address increment wraps: all ones +1 = 0. With inc=0, a burst rereads the same address.
- A push into a full FIFO cannot occur, because issue is gated on the full condition.
- Reset asserted mid-access: MEM_REQ drops asynchronously, the FSM returns to IDLE, and the FIFO is emptied. A late MEM_ACK after reset is ignored in IDLE.
- MEM_ACK seen in IDLE or RD_ISSUE with MEM_REQ=0 is ignored.

Test Plan:
- SETADDR addr=0x10 len=0 inc=1, then WRITE WD=0xDEADBEEF, ack after 3 cycles -> one MEM_REQ with WE=1, ADDR=0x10, WD=0xDEADBEEF held 3 cycles; addr becomes 0x11; BUSY back to 0.
- SETADDR addr=0xFE len=3 inc=1, READ, memory returns addr+0x100 -> reads at 0xFE, 0xFF, 0x00, 0x01; RD_COUNT=4; RD_HEAD=0x1FE; POP x4 gives 0x1FF, 0x100, 0x101, then RD_COUNT=0.
- DEPTH=8, READ with len=11 and no POP -> 8 beats complete, MEM_REQ stays 0 with BUSY=1; one POP -> the 9th request issues within 2 cycles.
- WRITE strobe during an active burst, then POP on empty after the burst is drained -> command dropped, ERR=1; CLEAR in IDLE -> ERR=0, RD_COUNT=0.
- RESET=0 while MEM_REQ=1 awaiting ack, ack arrives after release -> MEM_REQ=0 immediately; BUSY=0, RD_COUNT=0; no FIFO push.
- JT_UPDATE held high 50 cycles -> exactly one command executed; the JT_UPDATE→MEM_REQ delay is SYNC+2 cycles ±1 from the sampling edge.

Source files
------------

// File: rtl/jtag_mem_bridge.sv
// jtag_mem_bridge: CLK-domain command engine behind the virtual-JTAG chains.
// Syncs JT_UPDATE, decodes JT_CMD, drives a req/ack port, buffers reads in a FIFO.
// Ports: CLK/RESET(async, low); JT_* held chain outputs; MEM_* memory port;
//        RD_HEAD/RD_COUNT FIFO head/occupancy; BUSY = FSM not idle; ERR sticky.
module jtag_mem_bridge #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int LW    = 4,
  parameter int DEPTH = 8,
  parameter int SYNC  = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     JT_UPDATE,
  input  logic [2:0]               JT_CMD,
  input  logic                     JT_INC,
  input  logic [AW-1:0]            JT_ADDR,
  input  logic [LW-1:0]            JT_LEN,
  input  logic [DW-1:0]            JT_WD,
  output logic                     MEM_REQ,
  output logic                     MEM_WE,
  output logic [AW-1:0]            MEM_ADDR,
  output logic [DW-1:0]            MEM_WD,
  input  logic                     MEM_ACK,
  input  logic [DW-1:0]            MEM_RD,
  output logic [DW-1:0]            RD_HEAD,
  output logic [$clog2(DEPTH):0]   RD_COUNT,
  output logic                     BUSY,
  output logic                     ERR
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE, WR, RD_ISSUE, RD_WAIT
  } state_t;

  state_t          state;
  logic [SYNC-1:0] sync_q;
  logic            upd_q;
  logic            cmd_stb;
  logic [AW-1:0]   addr;
  logic [LW-1:0]   len;
  logic [LW-1:0]   beat;
  logic            inc;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW:0]     count;

  logic is_set, is_wr, is_rd;
  logic is_pop, is_clr;
  logic busy, full, empty;
  logic push, do_pop, do_clr;
  logic err_set;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], JT_UPDATE};
      upd_q  <= sync_q[SYNC-1];
    end
  end

  assign cmd_stb = sync_q[SYNC-1] & ~upd_q;

  assign is_set = cmd_stb && (JT_CMD == 3'b001);
  assign is_wr  = cmd_stb && (JT_CMD == 3'b010);
  assign is_rd  = cmd_stb && (JT_CMD == 3'b011);
  assign is_pop = cmd_stb && (JT_CMD == 3'b100);
  assign is_clr = cmd_stb && (JT_CMD == 3'b101);

  assign busy   = (state != IDLE);
  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign push   = (state == RD_WAIT) && MEM_ACK;
  assign do_pop = is_pop && !empty;
  assign do_clr = is_clr && !busy;

  assign err_set = (is_pop && empty) ||
                   (busy && (is_clr || is_set || is_wr || is_rd));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      MEM_REQ  <= 1'b0;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_WD   <= '0;
      addr     <= '0;
      len      <= '0;
      inc      <= 1'b0;
      beat     <= '0;
      ERR      <= 1'b0;
    end else begin
      if (err_set)     ERR <= 1'b1;
      else if (do_clr) ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_set: begin
              addr <= JT_ADDR;
              len  <= JT_LEN;
              inc  <= JT_INC;
            end
            is_wr: begin
              MEM_REQ  <= 1'b1;
              MEM_WE   <= 1'b1;
              MEM_ADDR <= addr;
              MEM_WD   <= JT_WD;
              state    <= WR;
            end
            is_rd: begin
              beat  <= len;
              state <= RD_ISSUE;
            end
            default: ;
          endcase
        end
        WR: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
            addr    <= addr + AW'(inc);
            state   <= IDLE;
          end
        end
        RD_ISSUE: begin
          // a pop landing this cycle frees the slot this beat will fill
          if (!full || do_pop) begin
            MEM_REQ  <= 1'b1;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= addr;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            addr    <= addr + AW'(inc);
            if (beat == '0) begin
              state <= IDLE;
            end else begin
              beat  <= beat - LW'(1);
              state <= RD_ISSUE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= MEM_RD;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (do_clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + PW'(1);
      if (do_pop) rptr <= rptr + PW'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  assign RD_HEAD  = empty ? '0 : mem[rptr];
  assign RD_COUNT = count;
  assign BUSY     = busy;

endmodule
